alu_share_arbiter: RTL and testbench

Arbitrates one combinational `alu` instance between two requesters: requester 0 is the execute stage and requester 1 is the branch/address unit. Each operation is accepted through a valid/ready handshake. Operands and the opcode are registered, the ALU is driven for one cycle, and the result and zero flag are captured. The captured response is held on the granted requester's response port until that requester accepts it. The block sits between the issue logic and the single ALU, and owns `alu_control_in`, `channel_a_in` and `channel_b_in` of that ALU.

---
 rtl/alu_share_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between execute (req 0) and branch/address (req 1); ALU_ARB_ROUND_ROBIN_EN selects round-robin, else req 0 has fixed priority.
// Latency: accept at T, ALU driven during T+1, response valid from T+2; one operation per 3 cycles at best.
// Backpressure: response is held until the granted requester takes it; no new request is accepted meanwhile.
module alu_share_arbiter #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REQ   = 2
) (
    input  logic                                clk_in,
    input  logic                                reset_n_in,
    input  logic [NUM_REQ-1:0]                  req_valid_in,
    input  logic [NUM_REQ-1:0][3:0]             req_op_in,
    input  logic [NUM_REQ-1:0][WORD_SIZE-1:0]   req_a_in,
    input  logic [NUM_REQ-1:0][WORD_SIZE-1:0]   req_b_in,
    output logic [NUM_REQ-1:0]                  req_ready_out,
    output logic [NUM_REQ-1:0]                  resp_valid_out,
    input  logic [NUM_REQ-1:0]                  resp_ready_in,
    output logic [WORD_SIZE-1:0]                resp_result_out,
    output logic                                resp_zero_out,
    output logic [3:0]                          alu_control_out,
    output logic [WORD_SIZE-1:0]                alu_a_out,
    output logic [WORD_SIZE-1:0]                alu_b_out,
    input  logic [WORD_SIZE-1:0]                alu_result_in,
    input  logic                                alu_zero_in
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 gnt_id_q, gnt_id_d;
    logic [3:0]           op_q, op_d;
    logic [WORD_SIZE-1:0] a_q, a_d;
    logic [WORD_SIZE-1:0] b_q, b_d;
    logic [WORD_SIZE-1:0] result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 any_vld;
    logic                 gnt_sel;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic                 ptr_q, ptr_d;
`endif

    // The pointer only matters under contention; a lone requester always wins.
    always_comb begin
        any_vld = |req_valid_in;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        gnt_sel = (&req_valid_in) ? ptr_q : req_valid_in[1];
`else
        gnt_sel = ~req_valid_in[0];
`endif
    end

    always_comb begin
        state_d         = state_q;
        gnt_id_d        = gnt_id_q;
        op_d            = op_q;
        a_d             = a_q;
        b_d             = b_q;
        result_d        = result_q;
        zero_d          = zero_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        ptr_d           = ptr_q;
`endif
        req_ready_out   = '0;
        resp_valid_out  = '0;
        alu_control_out = 4'b0000;
        alu_a_out       = '0;
        alu_b_out       = '0;
        case (state_q)
            IDLE: begin
                if (any_vld) begin
                    req_ready_out[gnt_sel] = 1'b1;
                    gnt_id_d = gnt_sel;
                    op_d     = req_op_in[gnt_sel];
                    a_d      = req_a_in[gnt_sel];
                    b_d      = req_b_in[gnt_sel];
                    state_d  = EXEC;
`ifdef ALU_ARB_ROUND_ROBIN_EN
                    ptr_d    = ~gnt_sel;
`endif
                end
            end
            EXEC: begin
                alu_control_out = op_q;
                alu_a_out       = a_q;
                alu_b_out       = b_q;
                result_d        = alu_result_in;
                zero_d          = alu_zero_in;
                state_d         = RESP;
            end
            RESP: begin
                resp_valid_out[gnt_id_q] = 1'b1;
                if (resp_ready_in[gnt_id_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q  <= IDLE;
            gnt_id_q <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            ptr_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    assign resp_result_out = result_q;
    assign resp_zero_out   = zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: per-requester expected-response queues plus a cycle-level
// arbitration model built from the grant/hold rules; an ALU model closes the loop.
module tb_alu_share_arbiter;

    localparam int W = 32;

    logic          clk_in = 1'b0;
    logic          reset_n_in = 1'b0;
    logic          v0 = 0, v1 = 0, rr0 = 0, rr1 = 0;
    logic [3:0]    op0 = 0, op1 = 0;
    logic [W-1:0]  a0 = 0, a1 = 0, b0 = 0, b1 = 0;
    logic [1:0]    req_ready_out, resp_valid_out;
    logic [W-1:0]  resp_result_out, alu_a_out, alu_b_out, alu_result_in;
    logic          resp_zero_out, alu_zero_in;
    logic [3:0]    alu_control_out;

    logic [32:0]   exp_q0[$];
    logic [32:0]   exp_q1[$];
    int            n_chk = 0;
    int            n_fail = 0;

    alu_share_arbiter #(.WORD_SIZE(W), .NUM_REQ(2)) dut (
        .clk_in(clk_in), .reset_n_in(reset_n_in),
        .req_valid_in({v1, v0}), .req_op_in({op1, op0}),
        .req_a_in({a1, a0}), .req_b_in({b1, b0}),
        .req_ready_out(req_ready_out), .resp_valid_out(resp_valid_out),
        .resp_ready_in({rr1, rr0}),
        .resp_result_out(resp_result_out), .resp_zero_out(resp_zero_out),
        .alu_control_out(alu_control_out), .alu_a_out(alu_a_out), .alu_b_out(alu_b_out),
        .alu_result_in(alu_result_in), .alu_zero_in(alu_zero_in)
    );

    // Behavioural ALU: {zero, result}; unknown codes give result 0, zero 1.
    function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = ($signed(a) < $signed(b)) ? '1 : '0;
            default: r = '0;
        endcase
        return {(r == '0), r};
    endfunction

    assign {alu_zero_in, alu_result_in} = alu_ref(alu_control_out, alu_a_out, alu_b_out);

    initial forever #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    // Monitor: arbitration/timing model plus scoreboard pop on response handshake.
    initial begin : mon
        int         m_phase;
        int         m_pid;
        int         w;
        logic [3:0] m_op;
        logic [W-1:0] m_a, m_b;
        logic [1:0] exp_rdy, exp_rv;
        logic       take;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        logic       m_ptr;
        m_ptr = 1'b0;
`endif
        m_phase = 0; m_pid = 0; m_op = 0; m_a = 0; m_b = 0;
        forever begin
            @(negedge clk_in);
            if (!reset_n_in) begin
                m_phase = 0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
                m_ptr = 1'b0;
`endif
                chk("reset_outputs", 128'({req_ready_out, resp_valid_out, resp_zero_out, resp_result_out,
                                           alu_control_out, alu_a_out, alu_b_out}), '0);
            end else begin
                exp_rdy = 2'b00;
                w = 0;
                if (m_phase == 0 && (v0 || v1)) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
                    w = (v0 && v1) ? int'(m_ptr) : (v1 ? 1 : 0);
`else
                    w = v0 ? 0 : 1;
`endif
                    exp_rdy = (w == 0) ? 2'b01 : 2'b10;
                end
                exp_rv = (m_phase == 2) ? ((m_pid == 0) ? 2'b01 : 2'b10) : 2'b00;
                chk("req_ready", 128'(req_ready_out), 128'(exp_rdy));
                chk("resp_valid", 128'(resp_valid_out), 128'(exp_rv));
                if (m_phase == 1)
                    chk("alu_drive_exec", 128'({alu_control_out, alu_a_out, alu_b_out}), 128'({m_op, m_a, m_b}));
                else
                    chk("alu_drive_quiet", 128'({alu_control_out, alu_a_out, alu_b_out}), '0);
                if (m_phase == 0) begin
                    if (exp_rdy != 2'b00) begin
                        m_pid = w;
                        m_op = (w == 1) ? op1 : op0;
                        m_a  = (w == 1) ? a1 : a0;
                        m_b  = (w == 1) ? b1 : b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
                        m_ptr = (w == 0);
`endif
                        m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    m_phase = 2;
                end else begin
                    take = (m_pid == 1) ? rr1 : rr0;
                    if ((m_pid == 0 && exp_q0.size() == 0) || (m_pid == 1 && exp_q1.size() == 0)) begin
                        n_chk++; n_fail++;
                        $display("FAIL scoreboard_empty: actual response for req %0d required none", m_pid);
                    end else if (m_pid == 0) begin
                        chk("resp_data_req0", 128'({resp_zero_out, resp_result_out}), 128'(exp_q0[0]));
                        if (take) void'(exp_q0.pop_front());
                    end else begin
                        chk("resp_data_req1", 128'({resp_zero_out, resp_result_out}), 128'(exp_q1[0]));
                        if (take) void'(exp_q1.pop_front());
                    end
                    if (take) m_phase = 0;
                end
            end
        end
    end

    // mode 0 random, 1 ADD/SUB-to-zero, 2 OR/SLT contention, 3 unsupported opcode
    task automatic present(input int i, input int mode);
        logic [3:0]   op;
        logic [W-1:0] a, b;
        logic [32:0]  e;
        a = $urandom; b = $urandom;
        case (mode)
            1: if (i == 0) begin op = 4'b0010; a = 5; b = 7; e = {1'b0, 32'd12}; end
               else begin op = 4'b0110; a = 32'h1234; b = 32'h1234; e = {1'b1, 32'd0}; end
            2: if (i == 0) begin op = 4'b0001; a = 32'hF0; b = 32'h0F; e = {1'b0, 32'hFF}; end
               else begin op = 4'b0111; a = 3; b = 9; e = {1'b0, 32'hFFFF_FFFF}; end
            3: begin op = 4'b1111; e = {1'b1, 32'd0}; end
            default: begin
                case ($urandom_range(0, 5))
                    0: op = 4'b0000;
                    1: op = 4'b0001;
                    2: op = 4'b0010;
                    3: op = 4'b0110;
                    4: op = 4'b0111;
                    default: op = 4'($urandom_range(0, 15));
                endcase
                if ($urandom_range(0, 3) == 0) b = a;
                e = alu_ref(op, a, b);
            end
        endcase
        if (i == 0) begin op0 = op; a0 = a; b0 = b; v0 = 1'b1; exp_q0.push_back(e); end
        else begin op1 = op; a1 = a; b1 = b; v1 = 1'b1; exp_q1.push_back(e); end
    endtask

    // bp: requester 0 withholds resp_ready for bp cycles of a held response.
    task automatic run(input int n0, input int n1, input int pres, input int rrp, input int mode, input int bp);
        int   left0, left1, cyc, held;
        logic acc0, acc1;
        left0 = n0; left1 = n1; cyc = 0; held = 0;
        while ((left0 > 0 || left1 > 0 || v0 || v1 || exp_q0.size() > 0 || exp_q1.size() > 0) && cyc < 3000) begin
            @(negedge clk_in);
            acc0 = v0 && req_ready_out[0];
            acc1 = v1 && req_ready_out[1];
            if (resp_valid_out[0] && !rr0) held++;
            @(posedge clk_in); #1;
            if (acc0) v0 = 1'b0;
            if (acc1) v1 = 1'b0;
            if (!v0 && left0 > 0 && $urandom_range(1, 100) <= pres) begin present(0, mode); left0--; end
            if (!v1 && left1 > 0 && $urandom_range(1, 100) <= pres) begin present(1, mode); left1--; end
            rr0 = (held < bp) ? 1'b0 : ($urandom_range(1, 100) <= rrp);
            rr1 = ($urandom_range(1, 100) <= rrp);
            cyc++;
        end
        if (cyc >= 3000) begin
            n_chk++; n_fail++;
            $display("FAIL run_timeout: actual %0d cycles required completion, mode %0d", cyc, mode);
        end
        rr0 = 1'b0; rr1 = 1'b0;
    endtask

    initial begin : main
        logic acc;
        repeat (3) @(negedge clk_in);
        @(posedge clk_in); #1 reset_n_in = 1'b1;

        run(1, 0, 100, 100, 1, 0);
        run(0, 1, 100, 100, 1, 0);
        run(1, 2, 100, 100, 1, 10);
        run(5, 5, 100, 100, 2, 0);
        run(3, 3, 100, 100, 3, 0);
        run(40, 40, 60, 50, 0, 0);

        // Reset while the ALU is being driven.
        @(posedge clk_in); #1;
        op0 = 4'b0010; a0 = 100; b0 = 23; v0 = 1'b1;
        exp_q0.push_back({1'b0, 32'd123});
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk_in);
            acc = req_ready_out[0];
        end
        if (!acc) begin
            n_chk++; n_fail++;
            $display("FAIL reset_test_accept: actual no ready required ready within 20 cycles");
        end
        @(posedge clk_in); #1;
        v0 = 1'b0;
        chk("exec_before_reset", 128'({alu_control_out, alu_a_out, alu_b_out}), 128'({4'b0010, 32'd100, 32'd23}));
        #2 reset_n_in = 1'b0;
        #1 chk("async_reset", 128'({req_ready_out, resp_valid_out, resp_zero_out, resp_result_out,
                                     alu_control_out, alu_a_out, alu_b_out}), '0);
        repeat (2) @(negedge clk_in);
        exp_q0.delete();
        exp_q1.delete();
        @(posedge clk_in); #1 reset_n_in = 1'b1;
        run(2, 2, 100, 100, 1, 0);

        repeat (3) @(negedge clk_in);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
